// File: rtl/pwm_deadtime_output.sv
// Complementary PWM gate stage: shadow-latched duty compare against the timebase
// count, followed by a dead-time FSM that drives non-overlapping high/low gates.
module pwm_deadtime_output #(
    parameter int CNT_WIDTH = 32,
    parameter int DT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 period_end,
    input  logic [CNT_WIDTH-1:0] duty_cycles,
    input  logic [DT_WIDTH-1:0]  dead_cycles,
    output logic                 pwm_h,
    output logic                 pwm_l,
    output logic [CNT_WIDTH-1:0] duty_active,
    output logic                 in_deadtime,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DT_TO_H = 3'd1,
        H_ON    = 3'd2,
        DT_TO_L = 3'd3,
        L_ON    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] duty_q, duty_d;
    logic                 ref_q, ref_d;
    logic                 run_q, run_d;
    logic [DT_WIDTH-1:0]  dt_cnt_q, dt_cnt_d;
    logic                 pwm_h_q, pwm_h_d;
    logic                 pwm_l_q, pwm_l_d;
    logic                 in_dt_q, in_dt_d;
    logic                 dt_zero;
    logic                 dt_expired;
    logic                 entering_dt;
    logic                 staying_dt;

    always_comb begin
        duty_d = duty_q;
        if (!enable || period_end) begin
            duty_d = duty_cycles;
        end
        ref_d = enable && (cnt < duty_q);
        run_d = enable;
    end

    assign dt_zero    = (dead_cycles == '0);
    assign dt_expired = (dt_cnt_q <= DT_WIDTH'(1));

    // run_q marks that ref_q already reflects an enabled compare, so the
    // first cycle after enable is spent in IDLE waiting for a valid reference.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_q) begin
                        if (ref_q) state_d = dt_zero ? H_ON : DT_TO_H;
                        else       state_d = dt_zero ? L_ON : DT_TO_L;
                    end
                end
                L_ON: begin
                    if (ref_q) state_d = dt_zero ? H_ON : DT_TO_H;
                end
                H_ON: begin
                    if (!ref_q) state_d = dt_zero ? L_ON : DT_TO_L;
                end
                DT_TO_H: begin
                    if (!ref_q)          state_d = L_ON;
                    else if (dt_expired) state_d = H_ON;
                end
                DT_TO_L: begin
                    if (ref_q)           state_d = H_ON;
                    else if (dt_expired) state_d = L_ON;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // dead_cycles is captured only on entry, so mid-dead-time edits are ignored.
    always_comb begin
        entering_dt = ((state_d == DT_TO_H) || (state_d == DT_TO_L)) && (state_d != state_q);
        staying_dt  = ((state_q == DT_TO_H) || (state_q == DT_TO_L)) && (state_d == state_q);
        dt_cnt_d    = dt_cnt_q;
        if (entering_dt) begin
            dt_cnt_d = dead_cycles;
        end else if (staying_dt && (dt_cnt_q != '0)) begin
            dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
        end
    end

    always_comb begin
        pwm_h_d = (state_d == H_ON);
        pwm_l_d = (state_d == L_ON);
        in_dt_d = (state_d == DT_TO_H) || (state_d == DT_TO_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            ref_q    <= 1'b0;
            run_q    <= 1'b0;
            dt_cnt_q <= '0;
            pwm_h_q  <= 1'b0;
            pwm_l_q  <= 1'b0;
            in_dt_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            ref_q    <= ref_d;
            run_q    <= run_d;
            dt_cnt_q <= dt_cnt_d;
            pwm_h_q  <= pwm_h_d;
            pwm_l_q  <= pwm_l_d;
            in_dt_q  <= in_dt_d;
        end
    end

    assign pwm_h       = pwm_h_q;
    assign pwm_l       = pwm_l_q;
    assign in_deadtime = in_dt_q;
    assign duty_active = duty_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_deadtime_output.sv
// Directed bench for pwm_deadtime_output: a behavioural timebase drives cnt and
// period_end; gate widths, edge timing, shadowing, disable and reset are checked.
module tb_pwm_deadtime_output;

    localparam int CW = 32;
    localparam int DW = 8;
    localparam int P  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CW-1:0] cnt;
    logic          period_end;
    logic [CW-1:0] duty_cycles;
    logic [DW-1:0] dead_cycles;
    logic          pwm_h;
    logic          pwm_l;
    logic [CW-1:0] duty_active;
    logic          in_deadtime;
    logic [2:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int h_n, l_n, dt_n, both_n;

    pwm_deadtime_output #(.CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cnt         (cnt),
        .period_end  (period_end),
        .duty_cycles (duty_cycles),
        .dead_cycles (dead_cycles),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .duty_active (duty_active),
        .in_deadtime (in_deadtime),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: DUT outputs are sampled 1 ns after the edge, then the timebase advances.
    task automatic tick();
        @(posedge clk);
        #1;
        if (enable) cnt = (cnt == CW'(P - 1)) ? '0 : cnt + 1;
        else        cnt = '0;
        period_end = enable && (cnt == CW'(P - 1));
    endtask

    task automatic measure(input int n);
        h_n = 0; l_n = 0; dt_n = 0; both_n = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            h_n    += int'(pwm_h);
            l_n    += int'(pwm_l);
            dt_n   += int'(in_deadtime);
            both_n += int'(pwm_h & pwm_l);
        end
    endtask

    task automatic restart(input logic [CW-1:0] d, input logic [DW-1:0] dd);
        enable = 1'b0;
        tick();
        tick();
        duty_cycles = d;
        dead_cycles = dd;
        tick();
        enable = 1'b1;
    endtask

    task automatic wait_cnt(input logic [CW-1:0] target, input string tag);
        int n;
        n = 0;
        while ((cnt != target) && (n < 2 * P)) begin
            tick();
            n++;
        end
        chk(tag, cnt, target);
    endtask

    initial begin
        int hc;
        rst = 1'b1; enable = 1'b0; cnt = '0; period_end = 1'b0;
        duty_cycles = 4; dead_cycles = 0;
        #3;
        chk("rst_h", pwm_h, 0);
        chk("rst_l", pwm_l, 0);
        chk("rst_dt", in_deadtime, 0);
        chk("rst_duty", duty_active, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("dis_shadow", duty_active, 4);

        // d=4, D=0
        enable = 1'b1;
        tick();
        chk("t1_k1_h", pwm_h, 0);
        chk("t1_k1_l", pwm_l, 0);
        tick();
        chk("t1_k2_h", pwm_h, 1);
        repeat (10) tick();
        measure(P);
        chk("t1_h", h_n, 4);
        chk("t1_l", l_n, 6);
        chk("t1_both", both_n, 0);
        chk("t1_dt", dt_n, 0);

        // duty 4 -> 7 written at cnt=2
        wait_cnt(0, "t3_sync");
        hc = 0;
        for (int i = 0; i < P; i++) begin
            if (cnt == 2) duty_cycles = 7;
            if (cnt == 9) chk("t3_hold", duty_active, 4);
            tick();
            hc += int'(pwm_h);
        end
        chk("t3_old_h", hc, 4);
        chk("t3_load", duty_active, 7);
        measure(P);
        chk("t3_new_h", h_n, 7);
        chk("t3_new_l", l_n, 3);

        // d=4, D=1
        restart(4, 1);
        repeat (12) tick();
        measure(P);
        chk("t2_h", h_n, 3);
        chk("t2_l", l_n, 5);
        chk("t2_dt", dt_n, 2);
        chk("t2_both", both_n, 0);

        // duty extremes
        restart(0, 0);
        repeat (12) tick();
        measure(P);
        chk("d0_h", h_n, 0);
        chk("d0_l", l_n, P);
        restart(12, 0);
        repeat (12) tick();
        measure(P);
        chk("d12_h", h_n, P);
        chk("d12_l", l_n, 0);

        // pulse shorter than the dead time is swallowed
        restart(1, 2);
        repeat (12) tick();
        measure(P);
        chk("short_h", h_n, 0);
        chk("short_l", l_n, P - 1);
        chk("short_dt", dt_n, 1);
        chk("short_both", both_n, 0);

        // disable mid-pulse, then re-enable with D=3
        restart(7, 3);
        repeat (12) tick();
        wait_cnt(5, "dis_sync");
        chk("dis_pre_h", pwm_h, 1);
        enable = 1'b0;
        tick();
        chk("dis_h", pwm_h, 0);
        chk("dis_l", pwm_l, 0);
        chk("dis_dt", in_deadtime, 0);
        chk("dis_state", dbg_state, 0);
        tick();
        enable = 1'b1;
        tick();
        chk("re_k1_dt", in_deadtime, 0);
        chk("re_k1_h", pwm_h, 0);
        tick();
        chk("re_k2_dt", in_deadtime, 1);
        tick();
        chk("re_k3_dt", in_deadtime, 1);
        tick();
        chk("re_k4_dt", in_deadtime, 1);
        chk("re_k4_h", pwm_h, 0);
        tick();
        chk("re_k5_h", pwm_h, 1);
        chk("re_k5_l", pwm_l, 0);
        chk("re_k5_dt", in_deadtime, 0);

        // asynchronous reset while pwm_h is high
        #2;
        rst = 1'b1;
        #1;
        chk("arst_h", pwm_h, 0);
        chk("arst_l", pwm_l, 0);
        chk("arst_dt", in_deadtime, 0);
        chk("arst_duty", duty_active, 0);
        @(posedge clk); #1;
        rst = 1'b0; cnt = '0; period_end = 1'b0;
        repeat (4) tick();
        chk("rec_k4_l", pwm_l, 0);
        chk("rec_k4_dt", in_deadtime, 1);
        tick();
        chk("rec_k5_l", pwm_l, 1);
        chk("rec_k5_h", pwm_h, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
